klingon_scan_display: RTL and testbench

KLINGON_SCAN_DISPLAY -- requirements
Module: klingon_scan_display

---
 rtl/klingon_pkg.sv | 21 ++
 rtl/klingon_scan_display_if.sv | 23 ++
 rtl/klingon_glyph_dec.sv | 19 +
 rtl/klingon_scan_display.sv | 113 +++++++++++
 tb/tb_klingon_scan_display.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/klingon_pkg.sv
// Shared types and glyph tables for the multiplexed seven-segment scanner.
// Patterns are {g,f,e,d,c,b,a}, active-low.
package klingon_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;
    localparam logic [3:0] KLINGON_MAX_CODE = 4'd9;

    // Packed MSB-first, so the leftmost entry is code 15 and the rightmost is code 0.
    localparam seg_t [15:0] HEX_GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam seg_t [15:0] KLINGON_GLYPHS = {
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h14,
        7'h38, 7'h0C, 7'h2A, 7'h1C, 7'h4B, 7'h5B, 7'h7B, 7'h63
    };

endpackage

// File: rtl/klingon_scan_display_if.sv
// Load/data bus and display outputs of the scanner, bundled for port hookup.
interface klingon_scan_display_if import klingon_pkg::*; #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     blank_mask;
    seg_t                  seg;
    logic [DIGITS-1:0]     an;
    logic                  pending;
    logic                  frame_done;
    logic                  code_err;

    modport master (
        output load, value, blank_mask,
        input  seg, an, pending, frame_done, code_err
    );

    modport slave (
        input  load, value, blank_mask,
        output seg, an, pending, frame_done, code_err
    );
endinterface

// File: rtl/klingon_glyph_dec.sv
// Combinational digit-code to segment-pattern decoder, table chosen at elaboration.
module klingon_glyph_dec import klingon_pkg::*; #(
    parameter int GLYPH_MODE = 1
) (
    input  logic [3:0] code,
    output seg_t       pattern,
    output logic       code_invalid
);

    always_comb begin
        pattern      = HEX_GLYPHS[code];
        code_invalid = 1'b0;
        if (GLYPH_MODE == 1) begin
            pattern      = KLINGON_GLYPHS[code];
            code_invalid = (code > KLINGON_MAX_CODE);
        end
    end

endmodule

// File: rtl/klingon_scan_display.sv
// Time-multiplexed seven-segment scanner with a shadow register that is
// committed only at frame boundaries, so a frame never mixes old and new digits.
module klingon_scan_display import klingon_pkg::*; #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GLYPH_MODE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    klingon_scan_display_if.slave  bus
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   shadow_val;
    logic [4*DIGITS-1:0]   disp_val;
    logic [DIGITS-1:0]     shadow_blank;
    logic [DIGITS-1:0]     disp_blank;
    logic                  pending_q;
    logic                  code_err_q;
    seg_t                  seg_q;
    logic                  tick;
    logic                  wrap;
    logic [3:0]            cur_code;
    logic                  cur_blank;
    seg_t                  glyph;
    logic                  glyph_bad;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load landing on the wrap cycle bypasses the shadow so it shows this frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val   <= '0;
            shadow_blank <= '0;
            disp_val     <= '0;
            disp_blank   <= '0;
            pending_q    <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow_val   <= bus.value;
                shadow_blank <= bus.blank_mask;
            end
            if (wrap && bus.load) begin
                disp_val   <= bus.value;
                disp_blank <= bus.blank_mask;
                pending_q  <= 1'b0;
            end else if (wrap && pending_q) begin
                disp_val   <= shadow_val;
                disp_blank <= shadow_blank;
                pending_q  <= 1'b0;
            end else if (bus.load) begin
                pending_q <= 1'b1;
            end
        end
    end

    always_comb begin
        cur_code  = '0;
        cur_blank = 1'b0;
        bus.an    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_code  = disp_val[4*i +: 4];
                cur_blank = disp_blank[i];
                bus.an[i] = (cnt == '0);
            end
        end
    end

    klingon_glyph_dec #(.GLYPH_MODE(GLYPH_MODE)) u_dec (
        .code         (cur_code),
        .pattern      (glyph),
        .code_invalid (glyph_bad)
    );

    // Forcing dark on tick makes seg dark for the whole count-0 gap of the next slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= SEG_OFF;
            code_err_q <= 1'b0;
        end else begin
            seg_q <= (tick || cur_blank || glyph_bad) ? SEG_OFF : glyph;
            if (!tick && !cur_blank && glyph_bad) begin
                code_err_q <= 1'b1;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = wrap;
    assign bus.code_err   = code_err_q;

endmodule

// File: tb/tb_klingon_scan_display.sv
// Directed bench: one hex-mode and one Klingon-mode scanner share the same stimulus.
module tb_klingon_scan_display;
    import klingon_pkg::*;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    seg_t       cap_seg  [4];
    seg_t       cap_kseg [4];
    seg_t       cap_end  [4];
    seg_t       cap_gseg [4];
    logic [3:0] cap_an   [4];
    logic [3:0] cap_gan  [4];

    klingon_scan_display_if #(.DIGITS(DIGITS)) hif ();
    klingon_scan_display_if #(.DIGITS(DIGITS)) kif ();

    assign kif.load       = hif.load;
    assign kif.value      = hif.value;
    assign kif.blank_mask = hif.blank_mask;

    klingon_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GLYPH_MODE(0)) dut_hex (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif)
    );

    klingon_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GLYPH_MODE(1)) dut_kl (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif)
    );

    always #5 clk = ~clk;

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!hif.frame_done && n < 200);
        if (!hif.frame_done) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_frame_done: no pulse within %0d cycles", n);
        end
    endtask

    task automatic load_word(input logic [15:0] v, input logic [3:0] bm);
        hif.load       = 1'b1;
        hif.value      = v;
        hif.blank_mask = bm;
        @(negedge clk);
        hif.load       = 1'b0;
    endtask

    // Expects to start at count 0 of slot 0; ends at count 0 of slot 0 of the next frame.
    task automatic capture_frame();
        for (int s = 0; s < DIGITS; s++) begin
            cap_gan[s]  = hif.an;
            cap_gseg[s] = hif.seg;
            @(negedge clk);
            cap_an[s]   = hif.an;
            cap_seg[s]  = hif.seg;
            cap_kseg[s] = kif.seg;
            repeat (SCAN_DIV - 2) @(negedge clk);
            cap_end[s]  = hif.seg;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cyc;
        hif.load = 1'b0;
        hif.value = '0;
        hif.blank_mask = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        total += 4;
        if (hif.seg !== 7'h7F) begin bad++; $display("[TB] FAIL reset_seg: got %h want 7f", hif.seg); end
        if (hif.an !== 4'hF) begin bad++; $display("[TB] FAIL reset_an: got %h want f", hif.an); end
        if (hif.pending !== 1'b0) begin bad++; $display("[TB] FAIL reset_pending: got %b want 0", hif.pending); end
        if (kif.code_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_code_err: got %b want 0", kif.code_err); end
        cyc = 1;
        while (hif.frame_done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc != 4 * SCAN_DIV) begin
            bad++;
            $display("[TB] FAIL reset_first_frame: got cycle %0d want %0d", cyc, 4 * SCAN_DIV);
        end
        @(negedge clk);
    endtask

    task automatic test_hex_scan();
        seg_t       exp_h [4] = '{7'h00, 7'h0E, 7'h79, 7'h40};
        seg_t       exp_k [4] = '{7'h14, 7'h7F, 7'h7B, 7'h63};
        logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        load_word(16'h01F8, 4'b0000);
        total++;
        if (hif.pending !== 1'b1) begin bad++; $display("[TB] FAIL hex_pending_set: got %b want 1", hif.pending); end
        wait_fd();
        total++;
        if (hif.pending !== 1'b1) begin bad++; $display("[TB] FAIL hex_pending_at_wrap: got %b want 1", hif.pending); end
        @(negedge clk);
        total += 2;
        if (hif.pending !== 1'b0) begin bad++; $display("[TB] FAIL hex_pending_clear: got %b want 0", hif.pending); end
        if (hif.frame_done !== 1'b0) begin bad++; $display("[TB] FAIL hex_fd_width: got %b want 0", hif.frame_done); end
        capture_frame();
        for (int s = 0; s < DIGITS; s++) begin
            total += 6;
            if (cap_seg[s] !== exp_h[s]) begin bad++; $display("[TB] FAIL hex_seg%0d: got %h want %h", s, cap_seg[s], exp_h[s]); end
            if (cap_end[s] !== exp_h[s]) begin bad++; $display("[TB] FAIL hex_seg_end%0d: got %h want %h", s, cap_end[s], exp_h[s]); end
            if (cap_kseg[s] !== exp_k[s]) begin bad++; $display("[TB] FAIL kl_seg%0d: got %h want %h", s, cap_kseg[s], exp_k[s]); end
            if (cap_an[s] !== exp_an[s]) begin bad++; $display("[TB] FAIL hex_an%0d: got %h want %h", s, cap_an[s], exp_an[s]); end
            if (cap_gan[s] !== 4'hF) begin bad++; $display("[TB] FAIL gap_an%0d: got %h want f", s, cap_gan[s]); end
            if (cap_gseg[s] !== 7'h7F) begin bad++; $display("[TB] FAIL gap_seg%0d: got %h want 7f", s, cap_gseg[s]); end
        end
    endtask

    task automatic test_last_load_wins();
        repeat (10) @(negedge clk);
        load_word(16'h1111, 4'b0000);
        repeat (6) @(negedge clk);
        load_word(16'h2222, 4'b0000);
        wait_fd();
        @(negedge clk);
        capture_frame();
        for (int s = 0; s < DIGITS; s++) begin
            total++;
            if (cap_seg[s] !== 7'h24) begin bad++; $display("[TB] FAIL last_load_seg%0d: got %h want 24", s, cap_seg[s]); end
        end
    endtask

    task automatic test_load_at_wrap();
        seg_t exp_h [4] = '{7'h02, 7'h12, 7'h19, 7'h30};
        wait_fd();
        total++;
        if (hif.pending !== 1'b0) begin bad++; $display("[TB] FAIL wrap_pending_before: got %b want 0", hif.pending); end
        load_word(16'h3456, 4'b0000);
        total++;
        if (hif.pending !== 1'b0) begin bad++; $display("[TB] FAIL wrap_pending_after: got %b want 0", hif.pending); end
        capture_frame();
        for (int s = 0; s < DIGITS; s++) begin
            total++;
            if (cap_seg[s] !== exp_h[s]) begin bad++; $display("[TB] FAIL wrap_seg%0d: got %h want %h", s, cap_seg[s], exp_h[s]); end
        end
    endtask

    task automatic test_blank();
        seg_t       exp_h [4] = '{7'h7F, 7'h00, 7'h7F, 7'h00};
        logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        load_word(16'h8888, 4'b0101);
        hif.blank_mask = 4'b0000;
        wait_fd();
        @(negedge clk);
        capture_frame();
        for (int s = 0; s < DIGITS; s++) begin
            total += 2;
            if (cap_seg[s] !== exp_h[s]) begin bad++; $display("[TB] FAIL blank_seg%0d: got %h want %h", s, cap_seg[s], exp_h[s]); end
            if (cap_an[s] !== exp_an[s]) begin bad++; $display("[TB] FAIL blank_an%0d: got %h want %h", s, cap_an[s], exp_an[s]); end
        end
    endtask

    task automatic test_reset_discard();
        repeat (5) @(negedge clk);
        load_word(16'hABCD, 4'b0000);
        total++;
        if (hif.pending !== 1'b1) begin bad++; $display("[TB] FAIL discard_pending_set: got %b want 1", hif.pending); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total += 3;
        if (hif.pending !== 1'b0) begin bad++; $display("[TB] FAIL discard_async_pending: got %b want 0", hif.pending); end
        if (hif.an !== 4'hF) begin bad++; $display("[TB] FAIL discard_async_an: got %h want f", hif.an); end
        if (hif.seg !== 7'h7F) begin bad++; $display("[TB] FAIL discard_async_seg: got %h want 7f", hif.seg); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fd();
        @(negedge clk);
        capture_frame();
        for (int s = 0; s < DIGITS; s++) begin
            total++;
            if (cap_seg[s] !== 7'h40) begin bad++; $display("[TB] FAIL discard_seg%0d: got %h want 40", s, cap_seg[s]); end
        end
    endtask

    task automatic test_klingon();
        seg_t exp_a [4] = '{7'h63, 7'h7B, 7'h5B, 7'h7F};
        seg_t exp_b [4] = '{7'h0C, 7'h38, 7'h14, 7'h06};
        total++;
        if (kif.code_err !== 1'b0) begin bad++; $display("[TB] FAIL kl_err_initial: got %b want 0", kif.code_err); end
        load_word(16'hC210, 4'b0000);
        wait_fd();
        @(negedge clk);
        total++;
        if (kif.code_err !== 1'b0) begin bad++; $display("[TB] FAIL kl_err_early: got %b want 0", kif.code_err); end
        capture_frame();
        total += 3;
        if (kif.code_err !== 1'b1) begin bad++; $display("[TB] FAIL kl_err_set: got %b want 1", kif.code_err); end
        if (hif.code_err !== 1'b0) begin bad++; $display("[TB] FAIL hex_err_quiet: got %b want 0", hif.code_err); end
        if (cap_seg[3] !== 7'h46) begin bad++; $display("[TB] FAIL hex_code_c: got %h want 46", cap_seg[3]); end
        for (int s = 0; s < DIGITS; s++) begin
            total++;
            if (cap_kseg[s] !== exp_a[s]) begin bad++; $display("[TB] FAIL kl_a_seg%0d: got %h want %h", s, cap_kseg[s], exp_a[s]); end
        end
        load_word(16'h9876, 4'b0000);
        wait_fd();
        @(negedge clk);
        capture_frame();
        total++;
        if (kif.code_err !== 1'b1) begin bad++; $display("[TB] FAIL kl_err_sticky: got %b want 1", kif.code_err); end
        for (int s = 0; s < DIGITS; s++) begin
            total++;
            if (cap_kseg[s] !== exp_b[s]) begin bad++; $display("[TB] FAIL kl_b_seg%0d: got %h want %h", s, cap_kseg[s], exp_b[s]); end
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (kif.code_err !== 1'b0) begin bad++; $display("[TB] FAIL kl_err_reset: got %b want 0", kif.code_err); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        hif.load = 1'b0;
        hif.value = '0;
        hif.blank_mask = '0;
        @(negedge clk);
        test_reset();
        test_hex_scan();
        test_last_load_wins();
        test_load_at_wrap();
        test_blank();
        test_reset_discard();
        test_klingon();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
